reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Successor of the single-domain boot reset generator. Holds NUM_DOMAINS reset outputs
//  after power-up or a soft restart, then releases them one by one with a fixed stagger.
//  Also provides a clock-enable divider in place of the toggled-register clock.
//  Sits beside the Controller in the top wrapper. Drives the controller, core and peripherals.
// PARAMETERS
//  NUM_DOMAINS  4   number of reset outputs; domain 0 is released first
//  CYCLES       20  clocks all domains stay in reset after reset/soft restart (>=1)
//  STAGGER      4   clocks between consecutive domain releases (0 = release together)
//  CNT_WIDTH    16  cycle-counter width; must hold CYCLES+(NUM_DOMAINS-1)*STAGGER
//  CLK_DIV      2   clk_en_o period in clocks (>=1; 1 = high every cycle)
// PORTS
//  clk             in   1            system clock
//  reset           in   1            synchronous, active-high reset
//  soft_reset_req  in   1            1-cycle pulse: restart the whole sequence
//  domain_hold     in   NUM_DOMAINS  level: force reset_o[i] high while 1
//  reset_o         out  NUM_DOMAINS  active-high reset per domain
//  clk_en_o        out  1            one-clock enable pulse every CLK_DIV clocks
//  all_released_o  out  1            1 when the sequence is complete (state RUN)
//  busy_o          out  1            1 in HOLD or STAGGER
// BEHAVIOUR
//  Reset values: reset_o = all 1s, clk_en_o=0, all_released_o=0, busy_o=1; state=HOLD, counters 0.
//  FSM (registered):
//   HOLD: cnt increments every clock.
//    - At cnt==CYCLES-1: go to STAGGER with idx=0, cnt=0, and release domain 0.
//   STAGGER: when cnt==STAGGER-1 (or at once if STAGGER==0), release domain idx+1 and increment idx.
//    - When the last domain is released: go to RUN.
//   RUN: stable. all_released_o=1 and busy_o=0.
//  Timing: with reset low from edge 0, reset_o[i] is first low after edge CYCLES+i*STAGGER.
//   all_released_o rises in the same cycle as reset_o[NUM_DOMAINS-1] falls.
//  Output registers: reset_o[i] = seq_rst[i] | domain_hold[i].
//   - Both updates and holds appear one clock after the input.
//   - Releasing a hold in RUN drops reset_o[i] one clock later. There is no re-stagger.
//  soft_reset_req, any state:
//   - Next clock: reset_o = all 1s, state=HOLD, cnt=0, idx=0, all_released_o=0.
//   - In HOLD/STAGGER it restarts the count.
//  reset has priority over soft_reset_req. Reset mid-sequence returns everything to reset values.
//  Divider: free-running dcnt counts 0..CLK_DIV-1. clk_en_o=1 in the cycle after dcnt==CLK_DIV-1.
//   - Cleared by reset only; unaffected by soft_reset_req.
//   - CLK_DIV==1: clk_en_o=1 every cycle after the first post-reset edge.
//  The sequence counts raw clk edges, never clk_en_o.
//  Counters saturate and do not wrap.
//  Elaboration error if CYCLES==0, CLK_DIV==0, or CNT_WIDTH is too small.
// STRUCTURE
//  Package reset_seq_pkg: state enum {HOLD, STAGGER, RUN} (2-bit) and a clog2-based width helper.
//  One sub-module: clk_enable_divider (CLK_DIV; clk, reset -> clk_en_o).
//  Sequencer FSM and output registers stay in this module.
// TESTING
//  1 Defaults, reset for 3 clks then low -> reset_o falls at edges 20,24,28,32 in order 0..3.
//    all_released_o=1 from edge 32.
//  2 soft_reset_req pulse at edge 50 (RUN) -> reset_o=4'hF after edge 51.
//    Releases at 51+20, +24, +28, +32.
//  3 domain_hold[2]=1 edges 10..60 -> reset_o[2] stays 1 until edge 61.
//    Other domains follow the test-1 times. all_released_o still at 32.
//  4 STAGGER=0, NUM_DOMAINS=8 -> all 8 outputs fall together at edge 20.
//  5 CLK_DIV=1,2,5 -> clk_en_o period 1/2/5. Unchanged phase across soft reset.
//    Resets to 0 on reset.
//  6 reset and soft_reset_req both high mid-STAGGER -> reset values.
//    Sequence restarts from reset deassertion.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the staggered reset sequencer.
// Imported by the sequencer top and by the clock-enable divider.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_STAGGER = 2'd1,
    S_RUN     = 2'd2
  } seq_state_t;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int unsigned width_for(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_enable_divider.sv
// Free-running clock-enable generator: one-cycle pulse every CLK_DIV clocks.
// Only the hard reset clears it, so its phase survives soft restarts.
module clk_enable_divider
  import reset_seq_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic clk_en_o
);

  localparam int DW = width_for(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] dcnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      dcnt_reg <= '0;
      clk_en_o <= 1'b0;
    end else begin
      clk_en_o <= (dcnt_reg == LAST);
      dcnt_reg <= (dcnt_reg == LAST) ? '0 : dcnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds all domains for CYCLES clocks, then releases
// them in index order STAGGER clocks apart. Outputs are registered behind the FSM.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int CYCLES      = 20,
  parameter int STAGGER     = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int CLK_DIV     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   soft_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_hold,
  output logic [NUM_DOMAINS-1:0] reset_o,
  output logic                   clk_en_o,
  output logic                   all_released_o,
  output logic                   busy_o
);

  localparam int IW = width_for(NUM_DOMAINS);
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] STAGGER_LAST = CNT_WIDTH'(STAGGER - 1);
  localparam logic [IW-1:0]        IDX_LAST     = IW'(NUM_DOMAINS - 1);
  localparam bit RELEASE_ALL = (STAGGER == 0) || (NUM_DOMAINS == 1);

  if (CYCLES < 1) begin : g_bad_cycles
    $error("reset_sequencer: CYCLES must be at least 1");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("reset_sequencer: CLK_DIV must be at least 1");
  end
  if (NUM_DOMAINS < 1) begin : g_bad_domains
    $error("reset_sequencer: NUM_DOMAINS must be at least 1");
  end
  if ((longint'(CYCLES) + longint'(NUM_DOMAINS - 1) * longint'(STAGGER))
      >= (longint'(1) << CNT_WIDTH)) begin : g_bad_cnt_width
    $error("reset_sequencer: CNT_WIDTH too small for CYCLES and STAGGER");
  end

  seq_state_t             state_reg;
  logic [CNT_WIDTH-1:0]   cnt_reg;
  logic [IW-1:0]          idx_reg;
  logic [IW-1:0]          idx_inc;
  logic [NUM_DOMAINS-1:0] seq_rst_reg;
  logic [NUM_DOMAINS-1:0] rst_next;

  assign idx_inc = idx_reg + 1'b1;

  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
    assign rst_next[gi] = seq_rst_reg[gi] | domain_hold[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_HOLD;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      seq_rst_reg    <= '1;
      reset_o        <= '1;
      all_released_o <= 1'b0;
      busy_o         <= 1'b1;
    end else begin
      // Status follows the FSM one clock late so it lines up with reset_o.
      reset_o        <= rst_next;
      all_released_o <= (state_reg == S_RUN);
      busy_o         <= (state_reg != S_RUN);

      if (soft_reset_req) begin
        state_reg   <= S_HOLD;
        cnt_reg     <= '0;
        idx_reg     <= '0;
        seq_rst_reg <= '1;
      end else begin
        case (state_reg)
          S_HOLD: begin
            if (cnt_reg == HOLD_LAST) begin
              cnt_reg <= '0;
              idx_reg <= '0;
              if (RELEASE_ALL) begin
                seq_rst_reg <= '0;
                state_reg   <= S_RUN;
              end else begin
                seq_rst_reg[0] <= 1'b0;
                state_reg      <= S_STAGGER;
              end
            end else if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_STAGGER: begin
            if (STAGGER == 0 || cnt_reg == STAGGER_LAST) begin
              seq_rst_reg[idx_inc] <= 1'b0;
              idx_reg              <= idx_inc;
              cnt_reg              <= '0;
              if (idx_inc == IDX_LAST) state_reg <= S_RUN;
            end else if (cnt_reg != '1) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_RUN: begin
            seq_rst_reg <= '0;
          end
          default: state_reg <= S_HOLD;
        endcase
      end
    end
  end

  clk_enable_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clk      (clk),
    .reset    (reset),
    .clk_en_o (clk_en_o)
  );

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus STAGGER=0/8-domain and
// CLK_DIV=1/5 variants sharing one clock and reset.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       soft_reset_req;
  logic [3:0] hold4;
  logic [7:0] hold8;

  logic [3:0] rst_a, rst_c, rst_d;
  logic [7:0] rst_b;
  logic       en_a, en_b, en_c, en_d;
  logic       rel_a, rel_b, rel_c, rel_d;
  logic       busy_a, busy_b, busy_c, busy_d;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  reset_sequencer dut_a (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .domain_hold(hold4),
    .reset_o(rst_a), .clk_en_o(en_a), .all_released_o(rel_a), .busy_o(busy_a));

  reset_sequencer #(.NUM_DOMAINS(8), .STAGGER(0)) dut_b (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .domain_hold(hold8),
    .reset_o(rst_b), .clk_en_o(en_b), .all_released_o(rel_b), .busy_o(busy_b));

  reset_sequencer #(.CLK_DIV(1)) dut_c (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .domain_hold(hold4),
    .reset_o(rst_c), .clk_en_o(en_c), .all_released_o(rel_c), .busy_o(busy_c));

  reset_sequencer #(.CLK_DIV(5)) dut_d (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .domain_hold(hold4),
    .reset_o(rst_d), .clk_en_o(en_d), .all_released_o(rel_d), .busy_o(busy_d));

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  // Three reset clocks; afterwards the next posedge is edge 0.
  task automatic do_reset();
    reset = 1'b1;
    soft_reset_req = 1'b0;
    hold4 = '0;
    hold8 = '0;
    repeat (3) tick();
    reset = 1'b0;
    edge_no = -1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (rst_a !== 4'hF || rel_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: got rst=%h rel=%b busy=%b expected rst=f rel=0 busy=1",
               rst_a, rel_a, busy_a);
    end
    checks++;
    if ({en_a, en_c, en_d} !== 3'b000) begin
      errors++;
      $display("FAIL reset_clk_en: got %b expected 000", {en_a, en_c, en_d});
    end
    checks++;
    if (rst_b !== 8'hFF || rel_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_8: got rst=%h rel=%b expected rst=ff rel=0", rst_b, rel_b);
    end
  endtask

  task automatic test_release();
    logic [3:0] exp_rst;
    for (int e = 0; e <= 40; e++) begin
      tick();
      for (int i = 0; i < 4; i++) exp_rst[i] = (edge_no >= 20 + 4 * i) ? 1'b0 : 1'b1;
      checks++;
      if (rst_a !== exp_rst || rel_a !== (edge_no >= 32) || busy_a !== (edge_no < 32)) begin
        errors++;
        $display("FAIL release edge %0d: got rst=%h rel=%b busy=%b expected rst=%h rel=%b busy=%b",
                 edge_no, rst_a, rel_a, busy_a, exp_rst, edge_no >= 32, edge_no < 32);
      end
    end
  endtask

  task automatic test_soft_reset();
    logic [3:0] exp_rst;
    logic       exp_rel;
    while (edge_no < 49) tick();
    for (int e = 50; e <= 91; e++) begin
      soft_reset_req = (edge_no + 1 == 50);
      tick();
      if (edge_no < 51) begin
        exp_rst = 4'h0;
        exp_rel = 1'b1;
      end else begin
        for (int i = 0; i < 4; i++) exp_rst[i] = (edge_no >= 51 + 20 + 4 * i) ? 1'b0 : 1'b1;
        exp_rel = (edge_no >= 51 + 32);
      end
      checks++;
      if (rst_a !== exp_rst || rel_a !== exp_rel) begin
        errors++;
        $display("FAIL soft_reset edge %0d: got rst=%h rel=%b expected rst=%h rel=%b",
                 edge_no, rst_a, rel_a, exp_rst, exp_rel);
      end
    end
    soft_reset_req = 1'b0;
  endtask

  task automatic test_domain_hold();
    logic [3:0] exp_rst;
    do_reset();
    for (int e = 0; e <= 70; e++) begin
      hold4 = (edge_no + 1 >= 10 && edge_no + 1 <= 60) ? 4'b0100 : 4'b0000;
      tick();
      for (int i = 0; i < 4; i++) exp_rst[i] = (edge_no >= 20 + 4 * i) ? 1'b0 : 1'b1;
      if (edge_no >= 10 && edge_no <= 60) exp_rst[2] = 1'b1;
      checks++;
      if (rst_a !== exp_rst || rel_a !== (edge_no >= 32)) begin
        errors++;
        $display("FAIL domain_hold edge %0d: got rst=%h rel=%b expected rst=%h rel=%b",
                 edge_no, rst_a, rel_a, exp_rst, edge_no >= 32);
      end
    end
    hold4 = '0;
  endtask

  task automatic test_stagger_zero();
    logic [7:0] exp_rst;
    do_reset();
    for (int e = 0; e <= 25; e++) begin
      tick();
      exp_rst = (edge_no >= 20) ? 8'h00 : 8'hFF;
      checks++;
      if (rst_b !== exp_rst || rel_b !== (edge_no >= 20) || busy_b !== (edge_no < 20)) begin
        errors++;
        $display("FAIL stagger_zero edge %0d: got rst=%h rel=%b busy=%b expected rst=%h rel=%b",
                 edge_no, rst_b, rel_b, busy_b, exp_rst, edge_no >= 20);
      end
    end
  endtask

  task automatic test_clk_enable();
    do_reset();
    for (int e = 0; e <= 29; e++) begin
      soft_reset_req = (edge_no + 1 == 12);
      tick();
      checks++;
      if (en_a !== (edge_no % 2 == 1) || en_c !== 1'b1 || en_d !== (edge_no % 5 == 4)) begin
        errors++;
        $display("FAIL clk_enable edge %0d: got div2=%b div1=%b div5=%b expected %b 1 %b",
                 edge_no, en_a, en_c, en_d, edge_no % 2 == 1, edge_no % 5 == 4);
      end
    end
    soft_reset_req = 1'b0;
    checks++;
    if (rst_a !== 4'hF) begin
      errors++;
      $display("FAIL clk_enable_soft: got rst=%h expected f", rst_a);
    end
  endtask

  task automatic test_reset_priority();
    logic [3:0] exp_rst;
    do_reset();
    while (edge_no < 25) tick();
    checks++;
    if (rst_a !== 4'b1100 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_stagger: got rst=%h busy=%b expected rst=c busy=1", rst_a, busy_a);
    end
    reset = 1'b1;
    soft_reset_req = 1'b1;
    tick();
    checks++;
    if (rst_a !== 4'hF || rel_a !== 1'b0 || busy_a !== 1'b1 || {en_a, en_c, en_d} !== 3'b000) begin
      errors++;
      $display("FAIL reset_priority: got rst=%h rel=%b busy=%b en=%b expected f 0 1 000",
               rst_a, rel_a, busy_a, {en_a, en_c, en_d});
    end
    reset = 1'b0;
    soft_reset_req = 1'b0;
    edge_no = -1;
    for (int e = 0; e <= 33; e++) begin
      tick();
      for (int i = 0; i < 4; i++) exp_rst[i] = (edge_no >= 20 + 4 * i) ? 1'b0 : 1'b1;
      checks++;
      if (rst_a !== exp_rst || rel_a !== (edge_no >= 32)) begin
        errors++;
        $display("FAIL restart edge %0d: got rst=%h rel=%b expected rst=%h rel=%b",
                 edge_no, rst_a, rel_a, exp_rst, edge_no >= 32);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    soft_reset_req = 1'b0;
    hold4 = '0;
    hold8 = '0;
    test_reset();
    test_release();
    test_soft_reset();
    test_domain_hold();
    test_stagger_zero();
    test_clk_enable();
    test_reset_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
